// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared encodings for the fetch/load-store memory arbiter.
//   owner_e      - which requester owns an outstanding memory request
//   SIZE_*       - mem_size / data_size encodings
//   mem_req_bus_w- width of the packed downstream request {req, wr, size, wstrb, addr, wdata}
package mem_req_arbiter_pkg;

   typedef enum logic {
      OWNER_INST = 1'b0,
      OWNER_DATA = 1'b1
   } owner_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   function automatic int mem_req_bus_w(input int addr_w, input int data_w);
      return 1 + 1 + 2 + 4 + addr_w + data_w;
   endfunction

   localparam int MEM_REQ_BUS = mem_req_bus_w(32, 32);

endpackage

// File: rtl/mem_owner_fifo.sv
// mem_owner_fifo: in-order tracker of accepted memory requests, one {owner, discard}
// entry per request still waiting for its response.
//   clk, reset      clock, synchronous active-high reset
//   push, push_owner record a newly accepted request and its owner
//   pop             retire the head entry (its response is on the bus this cycle)
//   flush_inst      mark every inst-owned entry, including one pushed now, as discard
//   head_owner/head_discard  head entry
//   full, empty, count       registered occupancy
module mem_owner_fifo
   import mem_req_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     push_owner,
   input  logic                     pop,
   input  logic                     flush_inst,
   output logic                     head_owner,
   output logic                     head_discard,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0] own;
   logic [DEPTH-1:0] disc;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == (PW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign head_owner   = own[rd_ptr];
   assign head_discard = disc[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         own    <= '0;
         disc   <= '0;
      end else begin
         // Flush may also mark free or just-popped slots; harmless, since a slot's
         // discard bit is rewritten on push and the popped head was already consumed.
         for (int i = 0; i < DEPTH; i++) begin
            if (do_push && wr_ptr == PW'(i)) begin
               own[i]  <= push_owner;
               disc[i] <= flush_inst && (push_owner == OWNER_INST);
            end else if (flush_inst && own[i] == OWNER_INST) begin
               disc[i] <= 1'b1;
            end
         end
         // DEPTH is a power of two, so pointers wrap naturally.
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (PW+1)'(1);
            2'b01:   cnt <= cnt - (PW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one SRAM-like memory port between instruction fetch and
// data load/store. Data has priority; a starvation counter forces an inst grant after
// STARVE_LIMIT consecutive data accepts while inst waits. Each accepted request's
// owner is tracked in order so responses are routed back; fetch responses issued
// before an inst_cancel are dropped.
//   clk, reset                        clock, synchronous active-high reset
//   inst_req/addr, inst_addr_ok       fetch request channel
//   inst_data_ok/rdata, inst_cancel   fetch response channel, flush
//   data_req/wr/size/wstrb/addr/wdata, data_addr_ok   load/store request channel
//   data_data_ok/rdata                load/store response channel
//   mem_req/wr/size/wstrb/addr/wdata, mem_addr_ok     downstream request
//   mem_data_ok/rdata                 downstream in-order response
//   busy                              requests outstanding
//   err                               sticky: response arrived with nothing outstanding
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_OUTST    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              inst_cancel,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [3:0]        data_wstrb,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [3:0]        mem_wstrb,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              err
);

   localparam int SW    = $clog2(STARVE_LIMIT + 1);
   localparam int CW    = $clog2(MAX_OUTST) + 1;
   localparam int REQ_W = mem_req_bus_w(ADDR_W, DATA_W);

   logic [SW-1:0]    starve_cnt;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             head_owner;
   logic             head_discard;
   logic             starved;
   logic             pick_data;
   logic             accept;
   logic             data_acc;
   logic             inst_acc;
   logic             pop;
   logic             push_owner;
   logic [REQ_W-1:0] inst_bus;
   logic [REQ_W-1:0] data_bus;
   logic [REQ_W-1:0] win_bus;
   logic             win_req;

   // ---------------- grant ----------------
   assign starved   = inst_req && (starve_cnt == SW'(STARVE_LIMIT));
   assign pick_data = data_req && !starved;

   // When data is not picked, either inst is requesting or nobody is, so the
   // req bit of the selected bus is exactly "someone wants the port".
   assign inst_bus = {inst_req, 1'b0, SIZE_WORD, 4'b0000, inst_addr, {DATA_W{1'b0}}};
   assign data_bus = {data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata};
   assign win_bus  = pick_data ? data_bus : inst_bus;
   assign {win_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = win_bus;

   assign mem_req      = win_req && !full && !reset;
   assign accept       = mem_req && mem_addr_ok;
   assign data_acc     = accept && pick_data;
   assign inst_acc     = accept && !pick_data;
   assign data_addr_ok = data_acc;
   assign inst_addr_ok = inst_acc;
   assign push_owner   = pick_data ? OWNER_DATA : OWNER_INST;

   // ---------------- response routing ----------------
   assign pop          = mem_data_ok && !empty && !reset;
   assign data_data_ok = pop && (head_owner == OWNER_DATA);
   assign inst_data_ok = pop && (head_owner == OWNER_INST) && !head_discard;
   assign data_rdata   = data_data_ok ? mem_rdata : '0;
   assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
   assign busy         = (count != '0);

   mem_owner_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (accept),
      .push_owner   (push_owner),
      .pop          (pop),
      .flush_inst   (inst_cancel),
      .head_owner   (head_owner),
      .head_discard (head_discard),
      .full         (full),
      .empty        (empty),
      .count        (count)
   );

   // ---------------- starvation guard and protocol error ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
         err        <= 1'b0;
      end else begin
         if (!inst_req || inst_acc)
            starve_cnt <= '0;
         else if (data_acc && starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + SW'(1);
         if (mem_data_ok && empty)
            err <= 1'b1;
      end
   end

endmodule
